// File: rtl/fifo_pkg.sv
// Shared definitions for the async FIFO: default geometry, Gray/binary
// conversion and bit counting. Functions operate on a 32-bit word so any
// pointer width up to 32 bits can use them; callers size-cast the result
// back to their own PTR_W = ADDR_WIDTH + 1.
package fifo_pkg;

    localparam int ADDR_WIDTH_DEF  = 4;
    localparam int SYNC_STAGES_DEF = 2;
    localparam int DEPTH           = 2 ** ADDR_WIDTH_DEF;
    localparam int PTR_W_MAX       = 32;

    typedef logic [PTR_W_MAX-1:0] ptr_word_t;

    // Binary to reflected Gray code; zero upper bits stay zero.
    function automatic ptr_word_t bin2gray(input ptr_word_t bin);
        return bin ^ (bin >> 1);
    endfunction

    // Gray to binary: each binary bit is the XOR of all Gray bits above and at it.
    function automatic ptr_word_t gray2bin(input ptr_word_t gray);
        ptr_word_t bin;
        bin[PTR_W_MAX-1] = gray[PTR_W_MAX-1];
        for (int i = PTR_W_MAX - 2; i >= 0; i--) begin
            bin[i] = bin[i+1] ^ gray[i];
        end
        return bin;
    endfunction

    // Number of set bits, used to detect multi-bit pointer changes.
    function automatic int unsigned popcount(input ptr_word_t v);
        int unsigned n;
        n = 0;
        for (int i = 0; i < PTR_W_MAX; i++) begin
            n = n + {31'd0, v[i]};
        end
        return n;
    endfunction

endpackage

// File: rtl/sync_nstage.sv
// Generic multi-flop synchroniser: a plain chain of asynchronously reset
// registers with no logic between stages. Used for the read pointer entering
// the write domain and equally usable for the write pointer entering the read domain.
module sync_nstage #(
    parameter int WIDTH  = 5,
    parameter int STAGES = 2
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic [WIDTH-1:0] d_i,
    output logic [WIDTH-1:0] q_o
);

    logic [WIDTH-1:0] stage_q [STAGES];

    // Shift the asynchronous input through the flop chain one stage per clock.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            for (int i = 0; i < STAGES; i++) begin
                stage_q[i] <= '0;
            end
        end else begin
            stage_q[0] <= d_i;
            for (int i = 1; i < STAGES; i++) begin
                stage_q[i] <= stage_q[i-1];
            end
        end
    end

    assign q_o = stage_q[STAGES-1];

endmodule

// File: rtl/sync_r2w_full.sv
// Write-domain side of the async FIFO: brings the read pointer across into
// wclk, owns the write pointer, and derives full, almost-full, fill level,
// overflow and a sticky flag for read pointers that break Gray coding.
module sync_r2w_full
    import fifo_pkg::*;
#(
    parameter int ADDR_WIDTH  = ADDR_WIDTH_DEF,
    parameter int SYNC_STAGES = SYNC_STAGES_DEF
) (
    input  logic                  wclk,
    input  logic                  wrst_n,
    input  logic [ADDR_WIDTH:0]   rptr,
    input  logic                  winc,
    input  logic [ADDR_WIDTH:0]   afull_thresh,
    input  logic                  err_clr,
    output logic [ADDR_WIDTH:0]   wptr,
    output logic [ADDR_WIDTH-1:0] waddr,
    output logic                  wfull,
    output logic                  walmost_full,
    output logic [ADDR_WIDTH:0]   wlevel,
    output logic                  wover,
    output logic                  gray_err
);

    localparam int PTR_W = ADDR_WIDTH + 1;
    localparam int AW    = ADDR_WIDTH;

    logic [PTR_W-1:0] wq_rptr;
    logic [PTR_W-1:0] rbin_s;
    logic [PTR_W-1:0] prev_q;
    logic [PTR_W-1:0] wbin_q, wbin_d;
    logic [PTR_W-1:0] wptr_q, wgray_d;
    logic [PTR_W-1:0] wlevel_q, level_d;
    logic             wfull_q, wfull_d;
    logic             walmost_q, walmost_d;
    logic             wover_q, wover_d;
    logic             gray_err_q, gray_err_d;
    logic             err_set;

    sync_nstage #(
        .WIDTH  (PTR_W),
        .STAGES (SYNC_STAGES)
    ) u_rptr_sync (
        .clk_i  (wclk),
        .rst_ni (wrst_n),
        .d_i    (rptr),
        .q_o    (wq_rptr)
    );

    // Next write pointer, level and flags; a synced read and a write in the
    // same cycle both land in the one level subtraction, so they cancel.
    always_comb begin
        rbin_s     = PTR_W'(gray2bin(ptr_word_t'(wq_rptr)));
        wbin_d     = wbin_q + PTR_W'(winc & ~wfull_q);
        wgray_d    = PTR_W'(bin2gray(ptr_word_t'(wbin_d)));
        level_d    = wbin_d - rbin_s;
        wfull_d    = (wgray_d == {~wq_rptr[AW:AW-1], wq_rptr[AW-2:0]});
        walmost_d  = (level_d >= afull_thresh);
        wover_d    = winc & wfull_q;
        err_set    = (popcount(ptr_word_t'(wq_rptr ^ prev_q)) > 1);
        gray_err_d = err_set | (gray_err_q & ~err_clr);
    end

    // Register pointer, flags and the previous synced pointer; reset drops everything at once.
    always_ff @(posedge wclk or negedge wrst_n) begin
        if (!wrst_n) begin
            wbin_q     <= '0;
            wptr_q     <= '0;
            prev_q     <= '0;
            wlevel_q   <= '0;
            wfull_q    <= 1'b0;
            walmost_q  <= 1'b0;
            wover_q    <= 1'b0;
            gray_err_q <= 1'b0;
        end else begin
            wbin_q     <= wbin_d;
            wptr_q     <= wgray_d;
            prev_q     <= wq_rptr;
            wlevel_q   <= level_d;
            wfull_q    <= wfull_d;
            walmost_q  <= walmost_d;
            wover_q    <= wover_d;
            gray_err_q <= gray_err_d;
        end
    end

    assign wptr         = wptr_q;
    assign waddr        = wbin_q[AW-1:0];
    assign wfull        = wfull_q;
    assign walmost_full = walmost_q;
    assign wlevel       = wlevel_q;
    assign wover        = wover_q;
    assign gray_err     = gray_err_q;

endmodule

// File: tb/tb_sync_r2w_full.sv
// Bench for sync_r2w_full: two instances (2 and 3 sync stages) share the same
// stimulus and are compared every cycle against a counting model of the FIFO.
module tb_sync_r2w_full;

    logic       wclk = 1'b0;
    logic       wrst_n;
    logic [4:0] rptr;
    logic       winc;
    logic [4:0] afull_thresh;
    logic       err_clr;

    logic [4:0] wptr2, wlevel2, wptr3, wlevel3;
    logic [3:0] waddr2, waddr3;
    logic       wfull2, wam2, wover2, gerr2;
    logic       wfull3, wam3, wover3, gerr3;

    int testCount = 0;
    int failCount = 0;

    // Model state, index 0 = two sync stages, index 1 = three.
    int         mWcnt  [2];
    int         mTotal [2];
    int         mLevel [2];
    bit         mFull  [2];
    bit         mAlmost[2];
    bit         mOver  [2];
    bit         mErr   [2];
    logic [4:0] rHist[$];
    int         readCount;

    always #5 wclk = ~wclk;

    sync_r2w_full #(.ADDR_WIDTH(4), .SYNC_STAGES(2)) dut2 (
        .wclk(wclk), .wrst_n(wrst_n), .rptr(rptr), .winc(winc),
        .afull_thresh(afull_thresh), .err_clr(err_clr),
        .wptr(wptr2), .waddr(waddr2), .wfull(wfull2), .walmost_full(wam2),
        .wlevel(wlevel2), .wover(wover2), .gray_err(gerr2)
    );

    sync_r2w_full #(.ADDR_WIDTH(4), .SYNC_STAGES(3)) dut3 (
        .wclk(wclk), .wrst_n(wrst_n), .rptr(rptr), .winc(winc),
        .afull_thresh(afull_thresh), .err_clr(err_clr),
        .wptr(wptr3), .waddr(waddr3), .wfull(wfull3), .walmost_full(wam3),
        .wlevel(wlevel3), .wover(wover3), .gray_err(gerr3)
    );

    function automatic int toGray(input int b);
        return b ^ (b >> 1);
    endfunction

    function automatic int fromGray(input int g);
        for (int b = 0; b < 32; b++) begin
            if (toGray(b) == g) return b;
        end
        return 0;
    endfunction

    // Read pointer visible in the write domain once n edges have sampled rptr.
    function automatic int syncedAt(input int n, input int stages);
        if (n >= stages) return int'(rHist[n-stages]);
        return 0;
    endfunction

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        testCount++;
        assert (observed === expected) else begin
            failCount++;
            $error("[TB] FAIL %s observed=%0d expected=%0d", tag, observed, expected);
        end
    endtask

    task automatic modelReset();
        for (int i = 0; i < 2; i++) begin
            mWcnt[i] = 0; mTotal[i] = 0; mLevel[i] = 0;
            mFull[i] = 0; mAlmost[i] = 0; mOver[i] = 0; mErr[i] = 0;
        end
        rHist.delete();
    endtask

    task automatic modelEdge();
        int n, wq, pv, nw, lvl;
        bit acc;
        n = rHist.size();
        for (int i = 0; i < 2; i++) begin
            wq  = syncedAt(n, i + 2);
            pv  = syncedAt(n - 1, i + 2);
            acc = winc && !mFull[i];
            nw  = (mWcnt[i] + int'(acc)) % 32;
            lvl = (nw - fromGray(wq) + 32) % 32;
            mOver[i]   = winc && mFull[i];
            mTotal[i]  = mTotal[i] + int'(acc);
            mWcnt[i]   = nw;
            mLevel[i]  = lvl;
            mFull[i]   = (lvl == 16);
            mAlmost[i] = (lvl >= int'(afull_thresh));
            mErr[i]    = ($countones(wq ^ pv) > 1) || (mErr[i] && !err_clr);
        end
        rHist.push_back(rptr);
    endtask

    task automatic checkInst(input int i, input logic [4:0] wp, input logic [3:0] wa,
                             input logic wf, input logic wam, input logic [4:0] wl,
                             input logic wo, input logic ge);
        string p;
        p = (i == 0) ? "ss2" : "ss3";
        checkOutput({p, "_wptr"},     {27'd0, wp}, toGray(mWcnt[i]));
        checkOutput({p, "_waddr"},    {28'd0, wa}, mWcnt[i] % 16);
        checkOutput({p, "_wfull"},    {31'd0, wf}, {31'd0, mFull[i]});
        checkOutput({p, "_walmost"},  {31'd0, wam}, {31'd0, mAlmost[i]});
        checkOutput({p, "_wlevel"},   {27'd0, wl}, mLevel[i]);
        checkOutput({p, "_wover"},    {31'd0, wo}, {31'd0, mOver[i]});
        checkOutput({p, "_gray_err"}, {31'd0, ge}, {31'd0, mErr[i]});
        checkOutput({p, "_full_eq_level16"}, {31'd0, wf}, {31'd0, (wl == 5'd16)});
    endtask

    task automatic checkAll();
        checkInst(0, wptr2, waddr2, wfull2, wam2, wlevel2, wover2, gerr2);
        checkInst(1, wptr3, waddr3, wfull3, wam3, wlevel3, wover3, gerr3);
    endtask

    // One clock: model follows the edge, outputs sampled 1ns later.
    task automatic applyStimulus();
        @(posedge wclk);
        modelEdge();
        #1;
        checkAll();
    endtask

    // Asynchronous reset between edges, checked at the same instant.
    task automatic applyReset();
        wrst_n = 1'b0;
        #1;
        modelReset();
        checkOutput("rst_wptr",     {27'd0, wptr2}, 0);
        checkOutput("rst_wlevel",   {27'd0, wlevel2}, 0);
        checkOutput("rst_wfull",    {31'd0, wfull2}, 0);
        checkOutput("rst_gray_err", {31'd0, gerr2}, 0);
        checkOutput("rst_wover",    {31'd0, wover2}, 0);
        checkAll();
        #1;
        wrst_n = 1'b1;
    endtask

    initial begin
        wrst_n = 1'b0; winc = 1'b0; rptr = 5'd0; afull_thresh = 5'd16; err_clr = 1'b0;
        modelReset();
        #12;
        checkAll();
        wrst_n = 1'b1;

        // Reset mid-fill at level 7, then first write after release.
        winc = 1'b1;
        repeat (7) applyStimulus();
        winc = 1'b0;
        checkOutput("s1_level7", {27'd0, wlevel2}, 7);
        applyReset();
        winc = 1'b1;
        applyStimulus();
        winc = 1'b0;
        checkOutput("s1_first_wptr", {27'd0, wptr2}, 1);

        // Sync latency: wbin=5, rptr steps to Gray 00011 (binary 2).
        applyReset();
        winc = 1'b1;
        repeat (5) applyStimulus();
        winc = 1'b0;
        rptr = 5'b00011;
        applyStimulus();
        checkOutput("s2_ss2_e1", {27'd0, wlevel2}, 5);
        applyStimulus();
        checkOutput("s2_ss2_e2", {27'd0, wlevel2}, 5);
        applyStimulus();
        checkOutput("s2_ss2_e3", {27'd0, wlevel2}, 3);
        checkOutput("s2_ss3_e3", {27'd0, wlevel3}, 5);
        applyStimulus();
        checkOutput("s2_ss3_e4", {27'd0, wlevel3}, 3);

        // Fill to 16 with no reads, then one overflowing write.
        rptr = 5'd0;
        applyReset();
        winc = 1'b1;
        repeat (16) applyStimulus();
        checkOutput("s3_wfull",  {31'd0, wfull2}, 1);
        checkOutput("s3_wlevel", {27'd0, wlevel2}, 16);
        checkOutput("s3_wptr",   {27'd0, wptr2}, 5'b11000);
        applyStimulus();
        checkOutput("s3_wover",      {31'd0, wover2}, 1);
        checkOutput("s3_wptr_hold",  {27'd0, wptr2}, 5'b11000);
        checkOutput("s3_waddr_hold", {28'd0, waddr2}, 0);
        winc = 1'b0;
        applyStimulus();
        checkOutput("s3_wover_pulse", {31'd0, wover2}, 0);

        // Almost full at threshold 12, then one synced read.
        rptr = 5'd0;
        applyReset();
        afull_thresh = 5'd12;
        winc = 1'b1;
        for (int k = 1; k <= 12; k++) begin
            applyStimulus();
            checkOutput($sformatf("s5_afull_w%0d", k), {31'd0, wam2}, (k >= 12) ? 1 : 0);
        end
        winc = 1'b0;
        rptr = 5'b00001;
        applyStimulus();
        applyStimulus();
        checkOutput("s5_afull_e2", {31'd0, wam2}, 1);
        applyStimulus();
        checkOutput("s5_afull_fall", {31'd0, wam2}, 0);
        checkOutput("s5_level11", {27'd0, wlevel2}, 11);

        // Gray error: bad jump, sticky, clear, clear coincident with new bad jump.
        rptr = 5'd0;
        afull_thresh = 5'd16;
        applyReset();
        rptr = 5'b00011;
        applyStimulus();
        applyStimulus();
        checkOutput("s6_err_e2", {31'd0, gerr2}, 0);
        applyStimulus();
        checkOutput("s6_err_e3", {31'd0, gerr2}, 1);
        repeat (2) applyStimulus();
        checkOutput("s6_err_sticky", {31'd0, gerr2}, 1);
        err_clr = 1'b1;
        applyStimulus();
        err_clr = 1'b0;
        checkOutput("s6_err_cleared", {31'd0, gerr2}, 0);
        rptr = 5'b00000;
        applyStimulus();
        applyStimulus();
        err_clr = 1'b1;
        applyStimulus();
        err_clr = 1'b0;
        checkOutput("s6_set_wins", {31'd0, gerr2}, 1);

        // Random traffic with a legal reader, wrapping the pointers many times.
        rptr = 5'd0;
        applyReset();
        readCount = 0;
        afull_thresh = 5'($urandom_range(0, 16));
        for (int c = 0; c < 800; c++) begin
            if (c == 400) afull_thresh = 5'($urandom_range(0, 16));
            winc = ($urandom_range(0, 3) != 0);
            if (readCount < mTotal[0] && $urandom_range(0, 2) != 0) readCount++;
            rptr = 5'(toGray(readCount % 32));
            applyStimulus();
            checkOutput("rnd_level_le16", {31'd0, (wlevel2 <= 5'd16)}, 1);
        end
        checkOutput("rnd_wrapped", {31'd0, (mTotal[0] > 64)}, 1);

        $display("[TB] %0d tests run, %0d failed", testCount, failCount);
        $finish;
    end

endmodule
